// File: rtl/filter_sched.sv
// rtl/filter_sched.sv - job sequencer that issues filter-index groups to the decoder
//
// Takes a job (base index, filter count), then issues NUM_MACRO consecutive
// indices per decoder request. After each request it waits for out_valid and
// idles GAP_CYCLES before the next request. When the job is exhausted it
// pulses done.
//
// Optional build macro: FILTER_SCHED_TIMEOUT_EN. When it is defined, a WAIT
// watchdog abandons the job after MAX_WAIT silent cycles and raises the
// sticky timeout_err flag.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   job_valid/job_ready   job handshake (job_ready is high only in IDLE)
//   job_base, job_count   first filter index, number of filters (clipped to OUT_CH)
//   in_valid              one-cycle request strobe to the decoder
//   WHICH_FILTER          per-macro index; macro m in [m*BIT_OUT_CH +: BIT_OUT_CH]
//   macro_en              per-macro qualifier for WHICH_FILTER
//   out_valid             decoder completion, sampled in WAIT only
//   busy, done            not-IDLE status; one-cycle end-of-job pulse
//   timeout_err           sticky watchdog error, cleared on job acceptance
module filter_sched #(
    parameter int NUM_MACRO  = 1,
    parameter int OUT_CH     = 64,
    parameter int GAP_CYCLES = 3,
    parameter int MAX_WAIT   = 100,
    localparam int BIT_OUT_CH = $clog2(OUT_CH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [BIT_OUT_CH-1:0]           job_base,
    input  logic [BIT_OUT_CH:0]             job_count,
    output logic                            in_valid,
    output logic [NUM_MACRO*BIT_OUT_CH-1:0] WHICH_FILTER,
    output logic [NUM_MACRO-1:0]            macro_en,
    input  logic                            out_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout_err
);
    localparam int CNT_W = BIT_OUT_CH + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [BIT_OUT_CH-1:0]           base_q, base_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [CNT_W-1:0]                issued_q, issued_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic [NUM_MACRO*BIT_OUT_CH-1:0] which_q, which_d;
    logic [NUM_MACRO-1:0]            en_q, en_d;
    logic                            err_q, err_d;
    logic [CNT_W:0]                  issued_next_w;
    logic [CNT_W-1:0]                clipped_count;

`ifdef FILTER_SCHED_TIMEOUT_EN
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT > 0);
`endif

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        count_d  = count_q;
        issued_d = issued_q;
        gap_d    = gap_q;
        err_d    = err_q;
        which_d  = '0;
        en_d     = '0;
`ifdef FILTER_SCHED_TIMEOUT_EN
        wait_d   = wait_q;
`endif
        // One bit wider than issued so the completion compare cannot wrap.
        issued_next_w = {1'b0, issued_q} + (CNT_W+1)'(NUM_MACRO);
        clipped_count = (job_count > CNT_W'(OUT_CH)) ? CNT_W'(OUT_CH) : job_count;

        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    base_d   = job_base;
                    count_d  = clipped_count;
                    issued_d = '0;
                    err_d    = 1'b0;
                    state_d  = (clipped_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FILTER_SCHED_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            S_WAIT: begin
                if (out_valid) begin
                    issued_d = issued_next_w[CNT_W-1:0];
                    if (issued_next_w >= {1'b0, count_q}) begin
                        state_d = S_DONE;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end
`ifdef FILTER_SCHED_TIMEOUT_EN
                // A response on the final permitted cycle wins over the timeout.
                else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Index/qualifier registers are loaded on entry to ISSUE, held through
        // WAIT and cleared everywhere else, so they line up with in_valid.
        if (state_d == S_ISSUE) begin
            for (int m = 0; m < NUM_MACRO; m++) begin
                which_d[m*BIT_OUT_CH +: BIT_OUT_CH] =
                    base_d + issued_d[BIT_OUT_CH-1:0] + BIT_OUT_CH'(m);
                en_d[m] = (({1'b0, issued_d} + (CNT_W+1)'(m)) < {1'b0, count_d});
            end
        end else if (state_d == S_WAIT) begin
            which_d = which_q;
            en_d    = en_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            gap_q    <= '0;
            which_q  <= '0;
            en_q     <= '0;
            err_q    <= 1'b0;
`ifdef FILTER_SCHED_TIMEOUT_EN
            wait_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            gap_q    <= gap_d;
            which_q  <= which_d;
            en_q     <= en_d;
            err_q    <= err_d;
`ifdef FILTER_SCHED_TIMEOUT_EN
            wait_q   <= wait_d;
`endif
        end
    end

    assign job_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign in_valid     = (state_q == S_ISSUE);
    assign done         = (state_q == S_DONE);
    assign WHICH_FILTER = which_q;
    assign macro_en     = en_q;
`ifdef FILTER_SCHED_TIMEOUT_EN
    assign timeout_err  = err_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule
